// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response bundle for the shared adder arbiter
//
// Groups the requester-side and consumer-side handshakes of adder_arbiter.
//   req_valid  [NUM_REQ]        per-requester request valid
//   req_ready  [NUM_REQ]        per-requester accept, one-hot or zero
//   req_data1  [NUM_REQ*WIDTH]  first operands, requester i at [i*WIDTH +: WIDTH]
//   req_data2  [NUM_REQ*WIDTH]  second operands, same packing
//   rsp_valid                   response register holds a result
//   rsp_ready                   consumer accepts the response
//   rsp_result [WIDTH]          registered sum
//   rsp_id     [ID_W]           requester that produced rsp_result
//   rsp_overflow                signed overflow of rsp_result
// master: requesters + consumer side. slave: the arbiter.
interface adder_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data1;
  logic [NUM_REQ*WIDTH-1:0] req_data2;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_result;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_overflow;

  modport master (
    output req_valid, req_data1, req_data2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_overflow
  );

  modport slave (
    input  req_valid, req_data1, req_data2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, rsp_overflow
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder between requesters
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      adder_arbiter_if.slave (request ports and response register)
// Optional feature macro: ADDER_ARB_OVERFLOW_EN
//   defined   - rsp_overflow registers the signed overflow of each sum
//   undefined - rsp_overflow is tied to 0
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  adder_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             can_accept;
  logic             transfer;
  logic [WIDTH-1:0] op_a, op_b, sum;
  logic [WIDTH-1:0] result_q;
  logic [ID_W-1:0]  id_q;
  int               idx;

  assign can_accept = (state == EMPTY) || bus.rsp_ready;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // reset_n gating keeps req_ready low throughout reset, even though the
  // EMPTY state alone would otherwise allow a grant.
  always_comb begin
    bus.req_ready = '0;
    if (reset_n && can_accept && grant_any)
      bus.req_ready = NUM_REQ'(1) << grant_id;
  end

  assign transfer = |(bus.req_valid & bus.req_ready);
  assign op_a     = bus.req_data1[int'(grant_id)*WIDTH +: WIDTH];
  assign op_b     = bus.req_data2[int'(grant_id)*WIDTH +: WIDTH];
  assign sum      = op_a + op_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (transfer) state_next = FULL;
      FULL:  if (bus.rsp_ready && !transfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      id_q     <= '0;
      ptr      <= '0;
    end else if (transfer) begin
      result_q <= sum;
      id_q     <= grant_id;
      ptr      <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
  end

`ifdef ADDER_ARB_OVERFLOW_EN
  logic ovf_q;

  // Overflow only when both operands share a sign the sum does not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= 1'b0;
    else if (transfer)
      ovf_q <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  assign bus.rsp_overflow = ovf_q;
`else
  assign bus.rsp_overflow = 1'b0;
`endif

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_result = result_q;
  assign bus.rsp_id     = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter
module tb_adder_arbiter;

  localparam int NUM_REQ = 3;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;
`ifdef ADDER_ARB_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [ID_W-1:0]  id;
    logic             ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_data1[i*WIDTH +: WIDTH] = a;
    bus.req_data2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push(input logic [WIDTH-1:0] res, input int id, input logic ovf);
    exp_t e;
    e.res = res;
    e.id  = ID_W'(id);
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted response is popped and compared.
  always @(negedge clock) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got result 0x%08h id %0d with empty scoreboard",
                 bus.rsp_result, bus.rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", bus.rsp_result, e.res);
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b1;
    bus.req_valid = '0;
    bus.req_data1 = '0;
    bus.req_data2 = '0;
    bus.rsp_ready = 1'b1;
    #1 reset_n = 1'b0;

    // 1. reset values, then a single request
    bus.req_valid = 3'b001;
    set_req(0, 32'd5, 32'd7);
    @(negedge clock);
    @(negedge clock);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_result", bus.rsp_result, 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    push(32'd12, 0, 1'b0);
    @(negedge clock);
    check("t1_req_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();

    // 2. round-robin with all requesters valid (pointer starts at 1)
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 1), 32'(10 * (i + 1)));
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int g;
      g = (1 + k) % NUM_REQ;
      push(32'(11 * (g + 1)), g, 1'b0);
      @(negedge clock);
      check("rr_req_ready", 32'(bus.req_ready), 32'(1 << g));
      if (k > 0) check("rr_no_gap", 32'(bus.rsp_valid), 32'd1);
      tick();
    end
    bus.req_valid = '0;
    @(negedge clock);
    tick();

    // 3. backpressure, then simultaneous drain + grant
    bus.req_valid = 3'b010;
    set_req(1, 32'h10, 32'h20);
    push(32'h30, 1, 1'b0);
    @(negedge clock);
    check("bp_first_grant", 32'(bus.req_ready), 32'b010);
    tick();
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd3, 32'd4);
    push(32'd7, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("bp_hold_result", bus.rsp_result, 32'h30);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_release_grant", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("bp_no_bubble", 32'(bus.rsp_valid), 32'd1);
    tick();

    // 4 + 6. wrap-around / overflow with sparse requests (pointer at 2)
    bus.req_valid = 3'b100;
    set_req(2, 32'hFFFF_FFFF, 32'h0000_0002);
    push(32'h0000_0001, 2, 1'b0);
    @(negedge clock);
    check("sparse_req2", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = 3'b001;
    set_req(0, 32'h7FFF_FFFF, 32'h0000_0001);
    push(32'h8000_0000, 0, OVF_ON);
    @(negedge clock);
    check("sparse_req0_immediate", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b010;
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    push(32'h0000_0000, 1, OVF_ON);
    @(negedge clock);
    check("sparse_req1", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    tick();

    // 5. reset mid-operation with a held response and pointer at 2
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b010;
    set_req(1, 32'd9, 32'd9);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("mid_rsp_valid_before", 32'(bus.rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    bus.req_valid = 3'b111;
    bus.rsp_ready = 1'b1;
    set_req(0, 32'd100, 32'd200);
    #1;
    check("mid_rsp_valid_dropped", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_result_cleared", bus.rsp_result, 32'd0);
    check("mid_req_ready_in_reset", 32'(bus.req_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    push(32'd300, 0, 1'b0);
    @(negedge clock);
    check("mid_first_grant", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    tick();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
